m68k_dtack_gen: RTL
===================

# m68k_dtack_gen

Bus-cycle acknowledge generator for the 68000 side of the Demon's World board. It sits directly downstream of the M68K chip-select decoder and consumes its region selects. For each bus cycle it inserts a per-region number of wait states, holds off program-ROM cycles until SDRAM returns data, and drives `cpu_dtack_n`. It also issues the ROM fetch request and flags ROM fetches that never complete.

## Interface
Parameters:
- `RAM_WAIT`, 1, wait cycles for work RAM (`ram_cs`)
- `SHARED_WAIT`, 4, wait cycles for Z80 shared RAM
- `PAL_WAIT`, 2, wait cycles for tile/sprite palette
- `SPR_WAIT`, 2, wait cycles for sprite RAM
- `IO_WAIT`, 0, wait cycles for register selects and unmapped accesses
- `ROM_TIMEOUT`, 255, max `clk_sys` cycles spent waiting for `rom_ok` (8-bit counter)

Ports:
- `clk_sys`  in  1  system clock; every register in the block is clocked by it
- `reset`  in  1  synchronous, active-high reset
- `cpu_as_n`  in  1  68000 address strobe
- `prog_rom_cs`  in  1  program ROM select
- `ram_cs`  in  1  work RAM select
- `shared_ram_cs`  in  1  Z80 shared RAM select
- `pal_cs`  in  1  `tile_palette_cs | sprite_palette_cs`
- `sprite_ram_cs`  in  1  sprite RAM select
- `io_cs`  in  1  OR of all register selects
- `rom_ok`  in  1  SDRAM data valid for the current ROM request
- `cpu_dtack_n`  out  1  data acknowledge to the 68000
- `rom_req`  out  1  one-cycle ROM fetch request pulse
- `cycle_busy`  out  1  high from edge detect until the cycle returns to IDLE
- `rom_timeout`  out  1  sticky flag, set when a ROM wait exceeds the timeout

## Operation
- Registered copy `as_n_d` of `cpu_as_n`. A cycle starts when `cpu_as_n==0 && as_n_d==1` is sampled in IDLE.
- States and transitions:
  - IDLE → DECODE on the start condition.
  - DECODE: latch the selects with fixed priority prog_rom > ram > shared > pal > sprite_ram > io. Unmapped accesses use `IO_WAIT`. Load `wait_cnt` with the region's wait value.
    - ROM region → ROM_WAIT, with `rom_req=1` for that one cycle and `to_cnt=0`.
    - Wait value 0 → ACK.
    - Otherwise → WAIT.
  - WAIT: decrement `wait_cnt` each cycle. When `wait_cnt==1` the next state is ACK.
  - ROM_WAIT:
    - `rom_ok==1` → ACK.
    - `to_cnt==ROM_TIMEOUT-1` → ACK and set `rom_timeout`.
    - Otherwise increment `to_cnt`.
  - ACK: `cpu_dtack_n=0`. Leave for IDLE when `cpu_as_n==1` is sampled.
- Abort: `cpu_as_n==1` sampled in DECODE, WAIT or ROM_WAIT → IDLE. `cpu_dtack_n` stays 1 and `rom_timeout` is unchanged.
- Selects are latched only in DECODE. Select changes after that point are ignored until the next cycle.
- `rom_timeout` is cleared only by `reset`.
- Multiple selects asserted at once is not an error: the priority order above applies.
- Back-to-back cycles: a new start requires `cpu_as_n` to be sampled high for at least one cycle (the IDLE entry cycle counts).

## Timing
- Reset values: `cpu_dtack_n=1`, `rom_req=0`, `cycle_busy=0`, `rom_timeout=0`, state IDLE, all counters 0. Reset applied mid-cycle forces the same values on the next edge.
- All outputs are registered.
- Let E0 be the edge at which the start condition is sampled.
  - `cycle_busy` rises at E0.
  - Non-ROM region with wait W: `cpu_dtack_n` falls at E0+2+W.
  - ROM region: `rom_req` is high for exactly the cycle after E0+1. `cpu_dtack_n` falls one edge after `rom_ok` is sampled high.
  - ROM timeout: `cpu_dtack_n` falls at E0+2+ROM_TIMEOUT, in the same edge as `rom_timeout` sets.
- `cpu_dtack_n` and `cycle_busy` return to 1/0 on the edge after `cpu_as_n==1` is sampled in ACK.

## Test plan
- Reset, then a work RAM access (`RAM_WAIT=1`) with AS falling at E0 → `dtack_n` low at E0+3, and released one edge after AS rises.
- `io_cs` access → `dtack_n` low at E0+2. Unmapped access (no select) gives the same timing.
- ROM access with `rom_ok` pulsed at E0+10 → `rom_req` high for one cycle at E0+1/E0+2, `dtack_n` low at E0+11, `rom_timeout` stays 0.
- ROM access with `rom_ok` held 0 → `dtack_n` low at E0+257 and `rom_timeout`=1. It stays 1 through the next cycles until `reset`.
- `shared_ram_cs` and `pal_cs` both asserted → shared-RAM timing applies, `dtack_n` low at E0+6.
- AS deasserted at E0+3 during a `SHARED_WAIT` cycle → `dtack_n` never asserts, `cycle_busy` falls, and the next AS edge starts cleanly. Also apply `reset` during ROM_WAIT → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/m68k_dtack_gen.sv
// m68k_dtack_gen: bus-cycle acknowledge generator for the 68000 side.
// Detects the falling address strobe, decodes the active region, inserts
// that region's wait states (or waits on SDRAM for program ROM) and then
// drives DTACK until the strobe is released. Tracks ROM fetches that stall.
module m68k_dtack_gen #(
  parameter int RAM_WAIT    = 1,
  parameter int SHARED_WAIT = 4,
  parameter int PAL_WAIT    = 2,
  parameter int SPR_WAIT    = 2,
  parameter int IO_WAIT     = 0,
  parameter int ROM_TIMEOUT = 255
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic cpu_as_n,
  input  logic prog_rom_cs,
  input  logic ram_cs,
  input  logic shared_ram_cs,
  input  logic pal_cs,
  input  logic sprite_ram_cs,
  input  logic io_cs,
  input  logic rom_ok,
  output logic cpu_dtack_n,
  output logic rom_req,
  output logic cycle_busy,
  output logic rom_timeout
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DECODE   = 3'd1;
  localparam logic [2:0] ST_WAIT     = 3'd2;
  localparam logic [2:0] ST_ROM_WAIT = 3'd3;
  localparam logic [2:0] ST_ACK      = 3'd4;

  localparam logic [7:0] W_RAM    = 8'(RAM_WAIT);
  localparam logic [7:0] W_SHARED = 8'(SHARED_WAIT);
  localparam logic [7:0] W_PAL    = 8'(PAL_WAIT);
  localparam logic [7:0] W_SPR    = 8'(SPR_WAIT);
  localparam logic [7:0] W_IO     = 8'(IO_WAIT);
  // Last value of the ROM wait counter before the fetch is declared stuck.
  localparam logic [7:0] TO_LAST  = 8'(ROM_TIMEOUT - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       to_hit_q, to_hit_d;
  logic       as_n_q;
  logic       dtack_n_q, dtack_n_d;
  logic       rom_req_q, rom_req_d;
  logic       busy_q, busy_d;
  logic       rom_timeout_q, rom_timeout_d;
  logic [7:0] sel_wait;

  // Wait-state value of the highest-priority non-ROM select; unmapped uses IO_WAIT.
  always_comb begin
    sel_wait = W_IO;
    if (ram_cs)             sel_wait = W_RAM;
    else if (shared_ram_cs) sel_wait = W_SHARED;
    else if (pal_cs)        sel_wait = W_PAL;
    else if (sprite_ram_cs) sel_wait = W_SPR;
    else if (io_cs)         sel_wait = W_IO;
  end

  // Bus-cycle state machine and registered output next-values.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    to_cnt_d   = to_cnt_q;
    to_hit_d   = to_hit_q;
    rom_req_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        to_hit_d   = 1'b0;
        to_cnt_d   = 8'd0;
        wait_cnt_d = 8'd0;
        if (!cpu_as_n && as_n_q) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (cpu_as_n) begin
          state_d = ST_IDLE;
        end else if (prog_rom_cs) begin
          state_d    = ST_ROM_WAIT;
          rom_req_d  = 1'b1;
          to_cnt_d   = 8'd0;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = sel_wait;
          state_d    = (sel_wait == 8'd0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cpu_as_n) begin
          state_d    = ST_IDLE;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q <= 8'd1) begin
          state_d    = ST_ACK;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q - 8'd1;
        end
      end
      ST_ROM_WAIT: begin
        if (cpu_as_n) begin
          state_d = ST_IDLE;
        end else if (rom_ok) begin
          state_d = ST_ACK;
        end else if (to_cnt_q == TO_LAST) begin
          // Timeout flag follows one edge later, together with DTACK.
          state_d  = ST_ACK;
          to_hit_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      ST_ACK: begin
        if (cpu_as_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // DTACK lags the ACK state by one edge so both its fall and its release
    // line up one edge after the deciding sample.
    dtack_n_d     = (state_q != ST_ACK);
    busy_d        = (state_d != ST_IDLE) || (state_q == ST_ACK);
    rom_timeout_d = rom_timeout_q || ((state_q == ST_ACK) && to_hit_q);
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= 8'd0;
      to_cnt_q      <= 8'd0;
      to_hit_q      <= 1'b0;
      as_n_q        <= 1'b1;
      dtack_n_q     <= 1'b1;
      rom_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      rom_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      to_cnt_q      <= to_cnt_d;
      to_hit_q      <= to_hit_d;
      as_n_q        <= cpu_as_n;
      dtack_n_q     <= dtack_n_d;
      rom_req_q     <= rom_req_d;
      busy_q        <= busy_d;
      rom_timeout_q <= rom_timeout_d;
    end
  end

  assign cpu_dtack_n = dtack_n_q;
  assign rom_req     = rom_req_q;
  assign cycle_busy  = busy_q;
  assign rom_timeout = rom_timeout_q;

endmodule
